mem32_initiator: RTL and testbench
==================================

Name: mem32_initiator

Overview:
- Bus-side initiator for the single-port 32x64k synchronous memory. Accepts read/write requests from a client (CPU or loader) over a valid/ready handshake.
- Drives the memory's address, write-enable and write-data pins, and absorbs the memory's 1-cycle read latency.
- Returns read data in order through a small response FIFO with backpressure.
- Sits between the core's load/store unit and the memory macro.

Parameters:
- WORD, 32, data width; must match the memory.
- ADDR, 16, address width; must match the memory.
- RSP_DEPTH, 2, response FIFO entries; must be ≥2 and a power of two.

Ports:
- clk  in  1  clock; the memory shares this clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR  word address.
- req_wdata  in  WORD  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  client takes response.
- rsp_rdata  out  WORD  read data.
- rsp_is_wr  out  1  response is a write ack; only meaningful with WRITE_ACK_EN, otherwise tied 0.
- mem_A  out  ADDR  to memory A.
- mem_W  out  1  to memory W.
- mem_D  out  WORD  to memory D.
- mem_Q  in  WORD  from memory Q.

Behaviour:
- Reset (async assert, sync deassert in the using design):
  - FIFO is emptied; in-flight flag is cleared.
  - rsp_valid=0, rsp_rdata=0, rsp_is_wr=0, req_ready=0 while rst_n=0, mem_W=0.
  - A reset in mid-transaction drops every pending read and queued response. No response appears after reset.
- Accept: a request is accepted when req_valid && req_ready at a clk edge (edge N).
- Memory drive:
  - mem_A/mem_D/mem_W are combinational from req_addr/req_wdata/req_we, qualified by acceptance.
  - mem_W = req_valid & req_ready & req_we. It is never 1 unless the request is accepted.
  - When idle, mem_A holds req_addr. The unqualified read that results is harmless.
- Read latency:
  - For a read accepted at edge N, the inflight flag is set at edge N.
  - mem_Q is captured into the FIFO at edge N+1.
  - rsp_valid is high in the cycle after edge N+1.
  - Minimum request-to-response latency is 2 edges. Throughput is 1 read/cycle while rsp_ready=1.
- Writes: complete at edge N. Without the optional feature they produce no response and do not touch the inflight flag.
- Credit rule:
  - req_ready = (fifo_count + inflight − pop) < RSP_DEPTH, where pop = rsp_valid & rsp_ready.
  - This guarantees that a captured mem_Q always has a FIFO slot, so no read data is ever lost.
  - Writes obey the same rule only with the optional feature; otherwise writes are always ready when not in reset.
- FIFO:
  - In-order; rsp_rdata comes from the head entry (not combinational from mem_Q).
  - A simultaneous push and pop keeps the count unchanged.
  - Push into a full FIFO is impossible by construction; assert it in simulation.
  - Read and write pointers wrap modulo RSP_DEPTH.
- Ordering: responses are returned in request order. A read following a write to the same address returns the new data, because the memory write completes first.
- The memory's o_reg is not updated on writes. The initiator never samples mem_Q except on the edge after a read issue.

Optional Feature:
- Macro: MEM32_INITIATOR_WRITE_ACK_EN.
- Defined:
  - Every accepted write pushes a response with rsp_is_wr=1 and rsp_rdata=0 at edge N+1, through the same inflight/credit path.
  - Responses stay strictly ordered across reads and writes.
- Undefined: writes are fire-and-forget and rsp_is_wr is constant 0.

Decomposition:
- Package mem32_pkg:
  - WORD_W=32, ADDR_W=16.
  - Response struct typedef {is_wr, rdata}.
  - Request struct typedef {we, addr, wdata}.
- Sub-module mem32_rsp_fifo: a generic synchronous FIFO parameterised by width and depth, with count output, async active-low reset, and clk/rst_n ports.
- The top level holds the credit logic, the inflight flag, and the memory pin drive.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> mem_W=0, rsp_valid=0, req_ready=0; release -> req_ready=1 next cycle.
- Write then read: write addr 0x0010 data 0xDEADBEEF, then read 0x0010 back-to-back -> exactly one response, rsp_rdata=0xDEADBEEF, rsp_valid high 2 edges after the read is accepted.
- Streaming: 8 reads of addresses 0..7 (preloaded with value = addr*3) with rsp_ready=1 -> req_ready stays 1, responses 0,3,...,21 arrive in order, one per cycle.
- Backpressure: rsp_ready=0, issue reads continuously -> exactly RSP_DEPTH accepted and req_ready falls. Raise rsp_ready -> all data correct, none dropped or duplicated.
- Mid-flight reset: accept a read of 0x0042, assert rst_n=0 on the next cycle -> no response ever appears and the FIFO is empty after release.
- With WRITE_ACK_EN: interleave W(0x5,0xA5), R(0x5), W(0x6,0x1) -> responses are {is_wr=1}, {is_wr=0, rdata=0xA5}, {is_wr=1}, in that order.

Source files
------------

// File: rtl/mem32_pkg.sv
// Shared widths and bundle types for the mem32 initiator.
// WORD_W/ADDR_W must match the 32x64k memory macro.
package mem32_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;

  typedef struct packed {
    logic              is_wr;
    logic [WORD_W-1:0] rdata;
  } rsp_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem32_rsp_fifo.sv
// Generic in-order response FIFO with occupancy count.
// DEPTH must be >= 2 and a power of two.
module mem32_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is only observed when count != 0.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && count == FULL)
  );

endmodule

// File: rtl/mem32_initiator.sv
// Valid/ready initiator for the 32x64k single-port sync memory.
// `define MEM32_INITIATOR_WRITE_ACK_EN to return write acks in order.
module mem32_initiator
  import mem32_pkg::*;
#(
  parameter int WORD      = WORD_W,
  parameter int ADDR      = ADDR_W,
  parameter int RSP_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ADDR-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_rdata,
  output logic            rsp_is_wr,
  output logic [ADDR-1:0] mem_A,
  output logic            mem_W,
  output logic [WORD-1:0] mem_D,
  input  logic [WORD-1:0] mem_Q
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(RSP_DEPTH);

  req_t          req;
  rsp_t          push_rsp;
  rsp_t          head;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          ready_en;
  logic          inflight;
  logic          inflight_wr;
  logic          credit_ok;
  logic          accept;
  logic          issue;
  logic          pop;

  assign req = '{we: req_we, addr: req_addr, wdata: req_wdata};

  assign pop    = rsp_valid & rsp_ready;
  assign used   = {1'b0, count}
                + {{CW{1'b0}}, inflight}
                - {{CW{1'b0}}, pop};
  assign credit_ok = used < DEPTH_V;
  assign accept = req_valid & req_ready;

`ifdef MEM32_INITIATOR_WRITE_ACK_EN
  assign req_ready = ready_en & credit_ok;
  assign issue     = accept;
`else
  assign req_ready = ready_en & (req_we | credit_ok);
  assign issue     = accept & ~req_we;
`endif

  assign mem_A = req.addr;
  assign mem_D = req.wdata;
  assign mem_W = accept & req.we;

  // One issue per edge, so the in-flight flag simply tracks last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en    <= 1'b0;
      inflight    <= 1'b0;
      inflight_wr <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      inflight    <= issue;
      inflight_wr <= issue & req_we;
    end
  end

  assign push_rsp.is_wr = inflight_wr;
  assign push_rsp.rdata = inflight_wr ? '0 : mem_Q;

  mem32_rsp_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .wdata (push_rsp),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  assign rsp_valid = count != '0;
  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign rsp_is_wr = rsp_valid & head.is_wr;

endmodule

// File: tb/tb_mem32_initiator.sv
// Scoreboard bench for mem32_initiator with a behavioural memory.
// Define MEM32_INITIATOR_WRITE_ACK_EN to exercise write acks.
module tb_mem32_initiator;
  import mem32_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_is_wr;
  logic [15:0] mem_A;
  logic        mem_W;
  logic [31:0] mem_D;
  bit   [31:0] mem_q;

  bit   [31:0] mem_arr [65536];
  bit   [31:0] ref_mem [65536];
  rsp_t        exp_q [$];
  int          pop_cyc [$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          last_acc = 0;
  bit          rand_rr = 1'b0;
  bit          rr_fixed = 1'b0;

  always #5 clk = ~clk;

  mem32_initiator #(
    .WORD(32), .ADDR(16), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_is_wr (rsp_is_wr),
    .mem_A     (mem_A),
    .mem_W     (mem_W),
    .mem_D     (mem_D),
    .mem_Q     (mem_q)
  );

  // Memory macro: 1-cycle read latency, output register held on writes.
  always @(posedge clk) begin
    if (mem_W) mem_arr[mem_A] <= mem_D;
    else       mem_q <= mem_arr[mem_A];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic issue(input bit we, input logic [15:0] a,
                       input logic [31:0] d, output bit acc);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
    acc = req_ready;
    chk(mem_W == (acc & we), "mem_W_qual", 32'(mem_W), 32'(acc & we));
    if (acc) begin
      last_acc = cyc;
      if (we) begin
        ref_mem[a] = d;
`ifdef MEM32_INITIATOR_WRITE_ACK_EN
        exp_q.push_back('{is_wr: 1'b1, rdata: 32'h0});
`endif
      end else begin
        exp_q.push_back('{is_wr: 1'b0, rdata: ref_mem[a]});
      end
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue_wait(input bit we, input logic [15:0] a,
                            input logic [31:0] d);
    bit acc;
    int n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      issue(we, a, d, acc);
      n++;
    end
    if (!acc) chk(1'b0, "req_timeout", 32'(n), 32'd50);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int n;
    int nrsp;
    fork
      forever begin
        @(posedge clk);
        #1;
        rsp_ready = rand_rr ? 1'($urandom_range(0, 1)) : rr_fixed;
      end
      forever begin : monitor
        rsp_t e;
        @(negedge clk);
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_rsp", rsp_rdata, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk(rsp_rdata == e.rdata, "rsp_rdata", rsp_rdata, e.rdata);
            chk(rsp_is_wr == e.is_wr, "rsp_is_wr",
                32'(rsp_is_wr), 32'(e.is_wr));
          end
        end
      end
    join_none

    // Reset with a pending write request
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0010;
    repeat (3) begin
      @(negedge clk);
      chk(mem_W == 1'b0, "rst_mem_W", 32'(mem_W), 32'd0);
      chk(rsp_valid == 1'b0, "rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk(req_ready == 1'b0, "rst_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk(req_ready == 1'b1, "ready_after_rst", 32'(req_ready), 32'd1);

    // Write then read back-to-back
    rr_fixed = 1'b1;
    repeat (2) @(negedge clk);
    pop_cyc.delete();
    issue_wait(1'b1, 16'h0010, 32'hDEADBEEF);
    issue_wait(1'b0, 16'h0010, 32'h0);
    n = last_acc;
    wait_drain();
`ifdef MEM32_INITIATOR_WRITE_ACK_EN
    nrsp = 2;
`else
    nrsp = 1;
`endif
    chk(pop_cyc.size() == nrsp, "wr_rd_count",
        32'(pop_cyc.size()), 32'(nrsp));
    if (pop_cyc.size() != 0)
      chk(pop_cyc[$] == n + 2, "rd_latency",
          32'(pop_cyc[$] - n), 32'd2);

    // Preload addr*3, then stream 8 reads
    for (int i = 0; i < 8; i++) issue_wait(1'b1, 16'(i), 32'(i * 3));
    wait_drain();
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 16'(i), 32'h0, acc);
      chk(acc, "stream_ready", 32'(acc), 32'd1);
    end
    wait_drain();
    chk(pop_cyc.size() == 8, "stream_count", 32'(pop_cyc.size()), 32'd8);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk(pop_cyc[i] == pop_cyc[i-1] + 1, "stream_gap",
          32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

    // Backpressure: exactly DEPTH reads accepted
    rr_fixed = 1'b0;
    repeat (2) @(negedge clk);
    pop_cyc.delete();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 16'(i), 32'h0, acc);
      if (acc) n++;
    end
    chk(n == DEPTH, "bp_accepted", 32'(n), 32'(DEPTH));
    chk(req_ready == 1'b0, "bp_ready_low", 32'(req_ready), 32'd0);
    rr_fixed = 1'b1;
    wait_drain();
    chk(pop_cyc.size() == DEPTH, "bp_rsp_count",
        32'(pop_cyc.size()), 32'(DEPTH));

    // Mid-flight reset drops the pending read
    mem_arr[16'h0042] = 32'h4242;
    ref_mem[16'h0042] = 32'h4242;
    issue(1'b0, 16'h0042, 32'h0, acc);
    chk(acc, "mf_accept", 32'(acc), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk(rsp_valid == 1'b0, "mf_rst_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(rsp_valid == 1'b0, "mf_post_empty", 32'(rsp_valid), 32'd0);
    end

    // Interleaved write/read/write
    pop_cyc.delete();
    issue_wait(1'b1, 16'h0005, 32'hA5);
    issue_wait(1'b0, 16'h0005, 32'h0);
    issue_wait(1'b1, 16'h0006, 32'h1);
    wait_drain();
`ifdef MEM32_INITIATOR_WRITE_ACK_EN
    nrsp = 3;
`else
    nrsp = 1;
`endif
    chk(pop_cyc.size() == nrsp, "wrw_count",
        32'(pop_cyc.size()), 32'(nrsp));

    // Random traffic with random backpressure
    rand_rr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
      end else begin
        issue($urandom_range(0, 2) == 0, 16'($urandom_range(0, 15)),
              $urandom, acc);
      end
    end
    rand_rr  = 1'b0;
    rr_fixed = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
